pc_source_ctrl: RTL

//  Sequencer driving the PC-source mux select and PC/EPC write enables in the multicycle MIPS core.

---
 rtl/pc_ctrl_pkg.sv | 65 ++++++
 rtl/exc_wait_counter.sv | 24 ++
 rtl/pc_source_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared PC-source select codes, instruction class codes, exception vector selects
// and the sequencer state encoding for the multicycle MIPS control path.
package pc_ctrl_pkg;

    localparam logic [2:0] PCSRC_ALU     = 3'b000;
    localparam logic [2:0] PCSRC_JUMP    = 3'b001;
    localparam logic [2:0] PCSRC_ALU_OUT = 3'b010;
    localparam logic [2:0] PCSRC_EPC     = 3'b011;
    localparam logic [2:0] PCSRC_VECTOR  = 3'b100;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BGT  = 3'b011;
    localparam logic [2:0] OP_BLE  = 3'b100;
    localparam logic [2:0] OP_JUMP = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;
    localparam logic [2:0] OP_RTE  = 3'b111;

    localparam logic [1:0] EXC_SEL_NONE   = 2'b00;
    localparam logic [1:0] EXC_SEL_OPCODE = 2'b01;
    localparam logic [1:0] EXC_SEL_OVF    = 2'b10;
    localparam logic [1:0] EXC_SEL_DIV0   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPD,
        ST_EXC_SAVE,
        ST_EXC_READ,
        ST_EXC_WAIT,
        ST_EXC_LOAD
    } state_t;

    // Invalid opcode outranks overflow, which outranks divide-by-zero.
    function automatic logic [1:0] exc_winner(input logic opcode, input logic ovf, input logic div0);
        if (opcode)
            return EXC_SEL_OPCODE;
        else if (ovf)
            return EXC_SEL_OVF;
        else if (div0)
            return EXC_SEL_DIV0;
        else
            return EXC_SEL_NONE;
    endfunction

    function automatic logic branch_taken(input logic [2:0] op, input logic zero, input logic gt);
        case (op)
            OP_BEQ:  return zero;
            OP_BNE:  return ~zero;
            OP_BGT:  return gt;
            OP_BLE:  return ~gt;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] class_source(input logic [2:0] op);
        case (op)
            OP_SEQ:  return PCSRC_ALU;
            OP_JUMP: return PCSRC_JUMP;
            OP_RTE:  return PCSRC_EPC;
            default: return PCSRC_ALU_OUT;
        endcase
    endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// 4-bit loadable down-counter that times the exception vector memory read.
module exc_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= 4'd0;
        else if (load)
            count <= load_value;
        else if (dec && count != 4'd0)
            count <= count - 4'd1;
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/pc_source_ctrl.sv
// PC-source sequencer: resolves branches/jumps/returns and walks the exception
// path (EPC save, vector byte read, PC load) with fully registered outputs.
module pc_source_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pc_req,
    input  logic [2:0] op_class,
    input  logic       alu_zero,
    input  logic       alu_gt,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] pc_source,
    output logic       pc_write,
    output logic       epc_write,
    output logic       exc_mem_read,
    output logic [1:0] exc_addr_sel,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic [1:0] exc_sel_q;
    logic       exc_any;
    logic       taken;
    logic [2:0] upd_source;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign exc_any    = exc_opcode | exc_ovf | exc_div0;
    assign taken      = branch_taken(op_class, alu_zero, alu_gt);
    assign upd_source = taken ? class_source(op_class) : PCSRC_ALU;
    assign cnt_load   = (state == ST_EXC_READ);
    assign cnt_dec    = (state == ST_EXC_WAIT) && !cnt_zero;

    exc_wait_counter u_wait (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (4'(MEM_LAT - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // Outputs are assigned for the state being entered, so they appear in the
    // same cycle as that state; anything not set below falls back to idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            exc_sel_q    <= EXC_SEL_NONE;
            pc_source    <= PCSRC_ALU;
            pc_write     <= 1'b0;
            epc_write    <= 1'b0;
            exc_mem_read <= 1'b0;
            exc_addr_sel <= EXC_SEL_NONE;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            pc_source    <= PCSRC_ALU;
            pc_write     <= 1'b0;
            epc_write    <= 1'b0;
            exc_mem_read <= 1'b0;
            exc_addr_sel <= EXC_SEL_NONE;
            busy         <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pc_req) begin
                        if (exc_any) begin
                            state     <= ST_EXC_SAVE;
                            exc_sel_q <= exc_winner(exc_opcode, exc_ovf, exc_div0);
                            epc_write <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state     <= ST_UPD;
                            pc_write  <= taken;
                            pc_source <= upd_source;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_UPD: begin
                    state <= ST_IDLE;
                end
                ST_EXC_SAVE: begin
                    state        <= ST_EXC_READ;
                    exc_mem_read <= 1'b1;
                    exc_addr_sel <= exc_sel_q;
                    busy         <= 1'b1;
                end
                ST_EXC_READ: begin
                    state        <= ST_EXC_WAIT;
                    exc_addr_sel <= exc_sel_q;
                    busy         <= 1'b1;
                end
                ST_EXC_WAIT: begin
                    if (cnt_zero) begin
                        state     <= ST_EXC_LOAD;
                        pc_source <= PCSRC_VECTOR;
                        pc_write  <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        exc_addr_sel <= exc_sel_q;
                        busy         <= 1'b1;
                    end
                end
                ST_EXC_LOAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
